// File: rtl/id_ex_skid.sv
// -----------------------------------------------------------------------------
// id_ex_skid
// Decode-to-execute pipeline boundary with a two-entry skid buffer.
//
// The module registers the decoded instruction payload and the forwarded
// register operands into the execute stage. in_ready_o comes straight from a
// flop, so execute backpressure never creates a combinational ready path back
// into decode. A load-use stall blocks capture, which puts a bubble into
// execute while decode holds its instruction.
//
// Optional feature: define ID_STALL_PERF_EN to add a saturating 32-bit
// counter of load-use stall cycles. Without it, stall_cnt_o is tied to 0 and
// no counter flops exist.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   flush_i       pipeline flush; empties the buffer and drops this cycle's input
//   in_valid_i    decode presents an instruction
//   in_payload_i  decoded instruction payload (PAYLOAD_W bits)
//   in_rddata_i   forwarded operands; port i occupies bits [32i+31:32i]
//   stall_i       load-use hazard on the presented instruction
//   in_ready_o    buffer can accept (low only when the skid entry is occupied)
//   out_valid_o   execute-stage entry valid
//   out_payload_o head payload
//   out_rddata_o  head operands
//   out_ready_i   execute consumes the head this cycle
//   stall_cnt_o   load-use stall cycle count (0 without ID_STALL_PERF_EN)
// -----------------------------------------------------------------------------
module id_ex_skid #(
   parameter int READ_PORTS = 2,
   parameter int PAYLOAD_W  = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   input  logic [PAYLOAD_W-1:0]     in_payload_i,
   input  logic [READ_PORTS*32-1:0] in_rddata_i,
   input  logic                     stall_i,
   output logic                     in_ready_o,
   output logic                     out_valid_o,
   output logic [PAYLOAD_W-1:0]     out_payload_o,
   output logic [READ_PORTS*32-1:0] out_rddata_o,
   input  logic                     out_ready_i,
   output logic [31:0]              stall_cnt_o
);

   localparam int RD_W = READ_PORTS * 32;

   logic                 m_valid_q,   m_valid_d;
   logic                 s_valid_q,   s_valid_d;
   logic [PAYLOAD_W-1:0] m_payload_q, m_payload_d;
   logic [PAYLOAD_W-1:0] s_payload_q, s_payload_d;
   logic [RD_W-1:0]      m_rddata_q,  m_rddata_d;
   logic [RD_W-1:0]      s_rddata_q,  s_rddata_d;

   logic in_fire;
   logic out_fire;

   assign in_ready_o    = ~s_valid_q;
   assign out_valid_o   = m_valid_q;
   assign out_payload_o = m_payload_q;
   assign out_rddata_o  = m_rddata_q;

   // Operands are captured only on in_fire; a stalled instruction is
   // re-presented later with freshly forwarded data.
   assign in_fire  = in_valid_i & ~s_valid_q & ~stall_i & ~flush_i;
   assign out_fire = m_valid_q & out_ready_i;

   always_comb begin
      m_valid_d   = m_valid_q;
      s_valid_d   = s_valid_q;
      m_payload_d = m_payload_q;
      s_payload_d = s_payload_q;
      m_rddata_d  = m_rddata_q;
      s_rddata_d  = s_rddata_q;

      if (flush_i) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else begin
         case ({m_valid_q, s_valid_q})
            2'b00: begin
               // EMPTY: a stall here simply leaves main invalid (bubble).
               if (in_fire) begin
                  m_valid_d   = 1'b1;
                  m_payload_d = in_payload_i;
                  m_rddata_d  = in_rddata_i;
               end
            end
            2'b10: begin
               // ONE: skid is written only when main holds and is not consumed.
               if (in_fire && out_fire) begin
                  m_payload_d = in_payload_i;
                  m_rddata_d  = in_rddata_i;
               end else if (in_fire) begin
                  s_valid_d   = 1'b1;
                  s_payload_d = in_payload_i;
                  s_rddata_d  = in_rddata_i;
               end else if (out_fire) begin
                  m_valid_d = 1'b0;
               end
            end
            2'b11: begin
               // FULL: in_fire is impossible since in_ready_o is low.
               if (out_fire) begin
                  m_payload_d = s_payload_q;
                  m_rddata_d  = s_rddata_q;
                  s_valid_d   = 1'b0;
               end
            end
            default: begin
               // Unreachable m=0,s=1: recover to EMPTY.
               m_valid_d = 1'b0;
               s_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q   <= 1'b0;
         s_valid_q   <= 1'b0;
         m_payload_q <= '0;
         s_payload_q <= '0;
         m_rddata_q  <= '0;
         s_rddata_q  <= '0;
      end else begin
         m_valid_q   <= m_valid_d;
         s_valid_q   <= s_valid_d;
         m_payload_q <= m_payload_d;
         s_payload_q <= s_payload_d;
         m_rddata_q  <= m_rddata_d;
         s_rddata_q  <= s_rddata_d;
      end
   end

`ifdef ID_STALL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where decode is held by a load-use hazard.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (in_valid_i && stall_i && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
module tb_id_ex_skid;

   localparam int PW = 64;
   localparam int RW = 64;

`ifdef ID_STALL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [PW-1:0] p;
      logic [RW-1:0] d;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          in_valid_i;
   logic [PW-1:0] in_payload_i;
   logic [RW-1:0] in_rddata_i;
   logic          stall_i;
   logic          in_ready_o;
   logic          out_valid_o;
   logic [PW-1:0] out_payload_o;
   logic [RW-1:0] out_rddata_o;
   logic          out_ready_i;
   logic [31:0]   stall_cnt_o;

   int tests = 0;
   int fails = 0;

   entry_t      sb[$];
   logic [31:0] exp_cnt = 32'd0;

   always #5 clk = ~clk;

   id_ex_skid #(.READ_PORTS(2), .PAYLOAD_W(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush_i),
      .in_valid_i    (in_valid_i),
      .in_payload_i  (in_payload_i),
      .in_rddata_i   (in_rddata_i),
      .stall_i       (stall_i),
      .in_ready_o    (in_ready_o),
      .out_valid_o   (out_valid_o),
      .out_payload_o (out_payload_o),
      .out_rddata_o  (out_rddata_o),
      .out_ready_i   (out_ready_i),
      .stall_cnt_o   (stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: predict with the queue model, advance, then compare on the
   // falling edge. The bench queue holds the entries the buffer should own.
   task automatic cycle(input string tag);
      logic   fire;
      logic   ofire;
      entry_t e;
      fire  = in_valid_i & (sb.size() < 2) & ~stall_i & ~flush_i;
      ofire = (sb.size() > 0) & out_ready_i;
      e.p   = in_payload_i;
      e.d   = in_rddata_i;
      @(posedge clk);
      if (rst) begin
         sb.delete();
         exp_cnt = 32'd0;
      end else begin
         if (ofire) void'(sb.pop_front());
         if (flush_i) sb.delete();
         if (fire) sb.push_back(e);
         if (PERF && in_valid_i && stall_i && !flush_i && exp_cnt != 32'hFFFF_FFFF)
            exp_cnt = exp_cnt + 32'd1;
      end
      @(negedge clk);
      chk({tag, ".out_valid"}, 64'(out_valid_o), 64'(sb.size() > 0));
      chk({tag, ".in_ready"},  64'(in_ready_o),  64'(sb.size() < 2));
      chk({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(exp_cnt));
      if (sb.size() > 0) begin
         chk({tag, ".payload"}, out_payload_o, sb[0].p);
         chk({tag, ".rddata"},  out_rddata_o,  sb[0].d);
      end
      $display("[TB] %s: out_valid=%0b in_ready=%0b payload=%h rddata=%h cnt=%0d",
               tag, out_valid_o, in_ready_o, out_payload_o, out_rddata_o, stall_cnt_o);
   endtask

   task automatic drive(input logic v, input logic [63:0] p, input logic [63:0] d,
                        input logic st, input logic rdy, input logic fl);
      in_valid_i   = v;
      in_payload_i = p;
      in_rddata_i  = d;
      stall_i      = st;
      out_ready_i  = rdy;
      flush_i      = fl;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);

      // Reset state
      cycle("rst0");
      cycle("rst1");
      chk("rst.payload_zero", out_payload_o, 64'h0);
      chk("rst.rddata_zero",  out_rddata_o,  64'h0);
      rst = 1'b0;

      // Stream 1,2,3 at full rate
      drive(1'b1, 64'd1, 64'h0000_0011_0000_0010, 1'b0, 1'b1, 1'b0); cycle("stream1");
      drive(1'b1, 64'd2, 64'h0000_0021_0000_0020, 1'b0, 1'b1, 1'b0); cycle("stream2");
      drive(1'b1, 64'd3, 64'h0000_0031_0000_0030, 1'b0, 1'b1, 1'b0); cycle("stream3");
      chk("stream.last_payload", out_payload_o, 64'd3);
      drive(1'b0, 64'd0, 64'h0, 1'b0, 1'b1, 1'b0); cycle("stream_drain");

      // Backpressure: A then B fill the buffer, then drain
      drive(1'b1, 64'hA, 64'hAAAA_0001, 1'b0, 1'b0, 1'b0); cycle("bp_a");
      drive(1'b1, 64'hB, 64'hBBBB_0002, 1'b0, 1'b0, 1'b0); cycle("bp_b");
      chk("bp.full_not_ready", 64'(in_ready_o), 64'd0);
      chk("bp.holds_a", out_payload_o, 64'hA);
      drive(1'b1, 64'hE, 64'hEEEE_0003, 1'b0, 1'b0, 1'b0); cycle("bp_hold");
      drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0); cycle("bp_emit_a");
      chk("bp.then_b", out_payload_o, 64'hB);
      cycle("bp_emit_b");
      cycle("bp_idle");

      // Load-use: two stalled cycles with stale data, then the real capture
      drive(1'b1, 64'h77, 64'h0000_DEAD_0000_DEAD, 1'b1, 1'b1, 1'b0); cycle("lu_stall1");
      cycle("lu_stall2");
      drive(1'b1, 64'h77, 64'h0000_1234_0000_1234, 1'b0, 1'b1, 1'b0); cycle("lu_capture");
      chk("lu.fresh_operands", out_rddata_o, 64'h0000_1234_0000_1234);
      drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0); cycle("lu_drain");

      // Flush from FULL with C presented
      drive(1'b1, 64'hA1, 64'h1, 1'b0, 1'b0, 1'b0); cycle("fl_a");
      drive(1'b1, 64'hB1, 64'h2, 1'b0, 1'b0, 1'b0); cycle("fl_b");
      drive(1'b1, 64'hC1, 64'h3, 1'b0, 1'b0, 1'b1); cycle("fl_flush");
      chk("fl.empty", 64'(out_valid_o), 64'd0);
      drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0); cycle("fl_after1");
      cycle("fl_after2");

      // Reset mid-operation after five stall cycles, with one entry held
      drive(1'b1, 64'h55, 64'h5, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle("rm_stall");
      drive(1'b1, 64'h56, 64'h6, 1'b0, 1'b0, 1'b0); cycle("rm_load");
      rst = 1'b1;
      drive(1'b1, 64'h57, 64'h7, 1'b0, 1'b0, 1'b0); cycle("rm_reset");
      chk("rm.payload_zero", out_payload_o, 64'h0);
      chk("rm.rddata_zero",  out_rddata_o,  64'h0);
      chk("rm.cnt_zero",     64'(stall_cnt_o), 64'h0);
      rst = 1'b0;
      drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0); cycle("rm_idle");

      // Counter: seven stall cycles, one of them flushed
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 64'h99, 64'h9, 1'b1, 1'b1, (i == 3) ? 1'b1 : 1'b0);
         cycle("cnt_stall");
      end
      chk("cnt.final", 64'(stall_cnt_o), PERF ? 64'd6 : 64'd0);
      drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0); cycle("cnt_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
